flex_pts_tx: RTL

FLEX_PTS_TX -- requirements
Module: flex_pts_tx

---
 rtl/flex_pts_tx.sv | 112 +++++++++++
 1 files changed

// File: rtl/flex_pts_tx.sv
// rtl/flex_pts_tx.sv - Parallel-to-serial frame transmitter with one-word holding buffer
// Frames are start(0), NUM_BITS data bits, stop(1); every bit is advanced by shift_enable.
module flex_pts_tx #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_enable,
  input  logic                tx_valid,
  input  logic [NUM_BITS-1:0] tx_data,
  output logic                tx_ready,
  output logic                serial_out,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int CNT_W = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state;
  logic [NUM_BITS-1:0] buffer;
  logic [NUM_BITS-1:0] shreg;
  logic                buffer_full;
  logic [CNT_W-1:0]    bit_cnt;
  logic                accept;

  assign tx_ready = !buffer_full;
  assign tx_busy  = (state != IDLE);
  assign accept   = tx_valid && !buffer_full;

  // The bit to put on the line next sits at the shift end of the register.
  function automatic logic head(input logic [NUM_BITS-1:0] w);
    return SHIFT_MSB ? w[NUM_BITS-1] : w[0];
  endfunction

  function automatic logic [NUM_BITS-1:0] advance(input logic [NUM_BITS-1:0] w);
    return SHIFT_MSB ? {w[NUM_BITS-2:0], 1'b0} : {1'b0, w[NUM_BITS-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      serial_out  <= 1'b1;
      tx_done     <= 1'b0;
      buffer_full <= 1'b0;
      bit_cnt     <= '0;
      buffer      <= '0;
      shreg       <= '0;
    end else begin
      tx_done <= 1'b0;
      // accept needs an empty buffer, so it never collides with a buffer load below
      if (accept) begin
        buffer      <= tx_data;
        buffer_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          serial_out <= 1'b1;
          if (buffer_full) begin
            shreg       <= buffer;
            buffer_full <= 1'b0;
            state       <= START;
            serial_out  <= 1'b0;
          end
        end
        START: begin
          if (shift_enable) begin
            state      <= DATA;
            bit_cnt    <= '0;
            serial_out <= head(shreg);
            shreg      <= advance(shreg);
          end
        end
        DATA: begin
          if (shift_enable) begin
            if (bit_cnt < LAST_BIT) begin
              serial_out <= head(shreg);
              shreg      <= advance(shreg);
              bit_cnt    <= bit_cnt + CNT_W'(1);
            end else begin
              state      <= STOP;
              serial_out <= 1'b1;
            end
          end
        end
        STOP: begin
          if (shift_enable) begin
            tx_done <= 1'b1;
            // chain straight into the next start bit when a word is already waiting
            if (buffer_full) begin
              shreg       <= buffer;
              buffer_full <= 1'b0;
              state       <= START;
              serial_out  <= 1'b0;
            end else begin
              state      <= IDLE;
              serial_out <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          serial_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
